// File: rtl/noc_route_pkg.sv
// Shared NoC route definitions: flit framing fields, one-hot port codes and
// the line/ring next-hop function used by every input port.
package noc_route_pkg;

    typedef enum logic [1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_HEAD     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    localparam logic [2:0] PORT_LOCAL = 3'b001;
    localparam logic [2:0] PORT_EAST  = 3'b010;
    localparam logic [2:0] PORT_WEST  = 3'b100;

    localparam int TYPE_LSB = 0;
    localparam int TYPE_W   = 2;
    localparam int DEST_LSB = TYPE_LSB + TYPE_W;

    // Wide enough for any node-ID width in use; callers zero-extend.
    localparam int ROUTE_ID_W = 16;

    function automatic logic [2:0] route_port(input logic [ROUTE_ID_W-1:0] dest,
                                              input logic [ROUTE_ID_W-1:0] node_id);
        logic [2:0] port;
        if (dest == node_id) begin
            port = PORT_LOCAL;
        end else if (dest > node_id) begin
            port = PORT_EAST;
        end else begin
            port = PORT_WEST;
        end
        return port;
    endfunction

endpackage

// File: rtl/s_route_compute.sv
// Per-input-port route computation: routes each HEAD flit to a one-hot next
// hop, holds it until the TAIL pops, and drops/flags malformed traffic.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no packet in flight; waiting for a HEAD at the buffer head
// ST_ROUTED | route issued and held; counting pops until TAIL or length cap
module s_route_compute
    import noc_route_pkg::*;
#(
    parameter int          FLIT_WIDTH    = 32,
    parameter int          NODE_ID_WIDTH = 4,
    parameter int unsigned NODE_ID       = 0,
    parameter int          MAX_PKT_LEN   = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ib_empty_i,
    input  logic [FLIT_WIDTH-1:0]              ib_flit_i,
    input  logic                               ib_read_i,
    output logic [2:0]                         nhr_address_o,
    output logic                               nhr_write_o,
    output logic                               route_valid_o,
    output logic                               ib_drop_o,
    output logic                               err_o,
    output logic [$clog2(MAX_PKT_LEN+1)-1:0]   flit_cnt_o
);

    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_LEN);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ROUTED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [2:0]       addr_q, addr_d;
    logic             write_q, write_d;
    logic             valid_q, valid_d;
    logic             drop_q, drop_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    flit_type_e             flit_type;
    logic [NODE_ID_WIDTH-1:0] flit_dest;
    logic                   is_head;
    logic                   is_tail;
    logic [2:0]             route;
    logic [CNT_W-1:0]       cnt_inc;

    assign flit_type = flit_type_e'(ib_flit_i[TYPE_LSB +: TYPE_W]);
    assign flit_dest = ib_flit_i[DEST_LSB +: NODE_ID_WIDTH];
    assign is_head   = (flit_type == FLIT_HEAD) || (flit_type == FLIT_HEADTAIL);
    assign is_tail   = (flit_type == FLIT_TAIL) || (flit_type == FLIT_HEADTAIL);
    assign route     = route_port(ROUTE_ID_W'(flit_dest), ROUTE_ID_W'(NODE_ID));
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = 1'b0;
        valid_d = valid_q;
        drop_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!ib_empty_i) begin
                    if (is_head) begin
                        addr_d  = route;
                        write_d = 1'b1;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_ROUTED;
                    end else if (!drop_q) begin
                        // The flit seen while a drop is in progress is the one being discarded.
                        drop_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            ST_ROUTED: begin
                if (ib_read_i && !ib_empty_i) begin
                    if (is_head && (cnt_q != '0)) begin
                        err_d = 1'b1;
                    end
                    if (is_tail) begin
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else if (cnt_inc == CNT_MAX) begin
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        cnt_d   = cnt_inc;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= PORT_LOCAL;
            write_q <= 1'b0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign nhr_address_o = addr_q;
    assign nhr_write_o   = write_q;
    assign route_valid_o = valid_q;
    assign ib_drop_o     = drop_q;
    assign err_o         = err_q;
    assign flit_cnt_o    = cnt_q;

endmodule

// File: tb/tb_s_route_compute.sv
// Directed bench for s_route_compute with NODE_ID=5 and MAX_PKT_LEN=4.
module tb_s_route_compute;

    localparam int FLIT_WIDTH    = 32;
    localparam int NODE_ID_WIDTH = 4;
    localparam int MAX_PKT_LEN   = 4;
    localparam int CNT_W         = $clog2(MAX_PKT_LEN + 1);

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  ib_empty_i;
    logic [FLIT_WIDTH-1:0] ib_flit_i;
    logic                  ib_read_i;
    logic [2:0]            nhr_address_o;
    logic                  nhr_write_o;
    logic                  route_valid_o;
    logic                  ib_drop_o;
    logic                  err_o;
    logic [CNT_W-1:0]      flit_cnt_o;

    int n_pass  = 0;
    int n_total = 0;

    s_route_compute #(
        .FLIT_WIDTH   (FLIT_WIDTH),
        .NODE_ID_WIDTH(NODE_ID_WIDTH),
        .NODE_ID      (5),
        .MAX_PKT_LEN  (MAX_PKT_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ib_empty_i   (ib_empty_i),
        .ib_flit_i    (ib_flit_i),
        .ib_read_i    (ib_read_i),
        .nhr_address_o(nhr_address_o),
        .nhr_write_o  (nhr_write_o),
        .route_valid_o(route_valid_o),
        .ib_drop_o    (ib_drop_o),
        .err_o        (err_o),
        .flit_cnt_o   (flit_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [FLIT_WIDTH-1:0] mk_flit(input logic [1:0] t, input logic [3:0] dest);
        return {26'h155_AA3, dest, t};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] t, input logic [3:0] dest, input logic rd);
        ib_empty_i = 1'b0;
        ib_flit_i  = mk_flit(t, dest);
        ib_read_i  = rd;
    endtask

    task automatic go_empty;
        ib_empty_i = 1'b1;
        ib_read_i  = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        go_empty();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        go_empty();
        ib_flit_i = '0;
        tick();
        tick();
        n_total++; if (nhr_address_o !== 3'b001) $display("FAIL reset_addr: got %b exp 001", nhr_address_o); else n_pass++;
        n_total++; if ({nhr_write_o, route_valid_o, ib_drop_o, err_o} !== 4'b0000)
            $display("FAIL reset_flags: got wr/vld/drop/err=%b exp 0000", {nhr_write_o, route_valid_o, ib_drop_o, err_o}); else n_pass++;
        n_total++; if (flit_cnt_o !== 3'd0) $display("FAIL reset_cnt: got %0d exp 0", flit_cnt_o); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_route_local;
        present(T_HEAD, 4'd5, 1'b0);
        tick();
        n_total++; if (nhr_write_o !== 1'b1) $display("FAIL local_write: got %b exp 1", nhr_write_o); else n_pass++;
        n_total++; if (nhr_address_o !== 3'b001) $display("FAIL local_addr: got %b exp 001", nhr_address_o); else n_pass++;
        n_total++; if (route_valid_o !== 1'b1) $display("FAIL local_valid: got %b exp 1", route_valid_o); else n_pass++;
        tick();
        n_total++; if (nhr_write_o !== 1'b0) $display("FAIL local_write_single: got %b exp 0", nhr_write_o); else n_pass++;
        present(T_HEAD, 4'd5, 1'b1);
        tick();
        n_total++; if (flit_cnt_o !== 3'd1) $display("FAIL local_cnt1: got %0d exp 1", flit_cnt_o); else n_pass++;
        present(T_TAIL, 4'd0, 1'b1);
        tick();
        n_total++; if ({route_valid_o, flit_cnt_o} !== {1'b0, 3'd0})
            $display("FAIL local_tail_end: got vld=%b cnt=%0d exp vld=0 cnt=0", route_valid_o, flit_cnt_o); else n_pass++;
        go_empty();
        tick();
    endtask

    task automatic test_east_packet;
        present(T_HEAD, 4'd9, 1'b0);
        tick();
        n_total++; if ({nhr_write_o, nhr_address_o} !== {1'b1, 3'b010})
            $display("FAIL east_route: got wr=%b addr=%b exp wr=1 addr=010", nhr_write_o, nhr_address_o); else n_pass++;
        present(T_HEAD, 4'd9, 1'b1);
        tick();
        n_total++; if (flit_cnt_o !== 3'd1) $display("FAIL east_cnt1: got %0d exp 1", flit_cnt_o); else n_pass++;
        present(T_BODY, 4'd0, 1'b1);
        tick();
        n_total++; if (flit_cnt_o !== 3'd2) $display("FAIL east_cnt2: got %0d exp 2", flit_cnt_o); else n_pass++;
        tick();
        n_total++; if (flit_cnt_o !== 3'd3) $display("FAIL east_cnt3: got %0d exp 3", flit_cnt_o); else n_pass++;
        n_total++; if ({nhr_write_o, nhr_address_o, route_valid_o} !== {1'b0, 3'b010, 1'b1})
            $display("FAIL east_hold: got wr=%b addr=%b vld=%b exp 0/010/1", nhr_write_o, nhr_address_o, route_valid_o); else n_pass++;
        present(T_TAIL, 4'd0, 1'b1);
        tick();
        n_total++; if ({route_valid_o, flit_cnt_o, err_o} !== {1'b0, 3'd0, 1'b0})
            $display("FAIL east_tail_at_max: got vld=%b cnt=%0d err=%b exp 0/0/0", route_valid_o, flit_cnt_o, err_o); else n_pass++;
        n_total++; if (nhr_address_o !== 3'b010) $display("FAIL east_idle_keep_addr: got %b exp 010", nhr_address_o); else n_pass++;
        go_empty();
        tick();
    endtask

    task automatic test_bubble;
        present(T_HEAD, 4'd9, 1'b0);
        tick();
        present(T_HEAD, 4'd9, 1'b1);
        tick();
        present(T_TAIL, 4'd0, 1'b1);
        tick();
        n_total++; if ({nhr_write_o, route_valid_o} !== 2'b00)
            $display("FAIL bubble_gap: got wr=%b vld=%b exp 0/0", nhr_write_o, route_valid_o); else n_pass++;
        present(T_HT, 4'd2, 1'b0);
        tick();
        n_total++; if ({nhr_write_o, nhr_address_o, route_valid_o} !== {1'b1, 3'b100, 1'b1})
            $display("FAIL bubble_west: got wr=%b addr=%b vld=%b exp 1/100/1", nhr_write_o, nhr_address_o, route_valid_o); else n_pass++;
        present(T_HT, 4'd2, 1'b1);
        tick();
        n_total++; if ({route_valid_o, flit_cnt_o, err_o} !== {1'b0, 3'd0, 1'b0})
            $display("FAIL headtail_single: got vld=%b cnt=%0d err=%b exp 0/0/0", route_valid_o, flit_cnt_o, err_o); else n_pass++;
        go_empty();
        tick();
    endtask

    task automatic test_drop;
        present(T_BODY, 4'd1, 1'b0);
        tick();
        n_total++; if ({ib_drop_o, err_o, nhr_write_o} !== 3'b110)
            $display("FAIL drop_first: got drop=%b err=%b wr=%b exp 1/1/0", ib_drop_o, err_o, nhr_write_o); else n_pass++;
        tick();
        n_total++; if (ib_drop_o !== 1'b0) $display("FAIL drop_no_back_to_back: got %b exp 0", ib_drop_o); else n_pass++;
        present(T_TAIL, 4'd1, 1'b0);
        tick();
        n_total++; if ({ib_drop_o, route_valid_o} !== 2'b10)
            $display("FAIL drop_tail: got drop=%b vld=%b exp 1/0", ib_drop_o, route_valid_o); else n_pass++;
        go_empty();
        tick();
        tick();
        n_total++; if ({ib_drop_o, err_o, nhr_write_o} !== 3'b010)
            $display("FAIL drop_err_sticky: got drop=%b err=%b wr=%b exp 0/1/0", ib_drop_o, err_o, nhr_write_o); else n_pass++;
    endtask

    task automatic test_max_len;
        present(T_HEAD, 4'd7, 1'b0);
        tick();
        present(T_HEAD, 4'd7, 1'b1);
        tick();
        present(T_BODY, 4'd0, 1'b1);
        tick();
        tick();
        n_total++; if ({flit_cnt_o, err_o, route_valid_o} !== {3'd3, 1'b0, 1'b1})
            $display("FAIL maxlen_before: got cnt=%0d err=%b vld=%b exp 3/0/1", flit_cnt_o, err_o, route_valid_o); else n_pass++;
        tick();
        n_total++; if ({flit_cnt_o, err_o, route_valid_o} !== {3'd4, 1'b1, 1'b0})
            $display("FAIL maxlen_hit: got cnt=%0d err=%b vld=%b exp 4/1/0", flit_cnt_o, err_o, route_valid_o); else n_pass++;
        present(T_HEAD, 4'd3, 1'b0);
        tick();
        n_total++; if ({nhr_write_o, nhr_address_o, flit_cnt_o} !== {1'b1, 3'b100, 3'd0})
            $display("FAIL maxlen_idle_reroute: got wr=%b addr=%b cnt=%0d exp 1/100/0", nhr_write_o, nhr_address_o, flit_cnt_o); else n_pass++;
        do_reset();
    endtask

    task automatic test_mid_head;
        present(T_HEAD, 4'd5, 1'b0);
        tick();
        present(T_HEAD, 4'd5, 1'b1);
        tick();
        n_total++; if (err_o !== 1'b0) $display("FAIL midhead_first_ok: got err=%b exp 0", err_o); else n_pass++;
        tick();
        n_total++; if ({err_o, route_valid_o, flit_cnt_o} !== {1'b1, 1'b1, 3'd2})
            $display("FAIL midhead_err: got err=%b vld=%b cnt=%0d exp 1/1/2", err_o, route_valid_o, flit_cnt_o); else n_pass++;
        present(T_HT, 4'd5, 1'b1);
        tick();
        n_total++; if ({route_valid_o, flit_cnt_o} !== {1'b0, 3'd0})
            $display("FAIL midheadtail_end: got vld=%b cnt=%0d exp 0/0", route_valid_o, flit_cnt_o); else n_pass++;
        do_reset();
    endtask

    task automatic test_mid_reset;
        present(T_HEAD, 4'd9, 1'b0);
        tick();
        present(T_HEAD, 4'd9, 1'b1);
        tick();
        present(T_BODY, 4'd0, 1'b1);
        tick();
        present(T_BODY, 4'd0, 1'b0);
        reset = 1'b0;
        tick();
        n_total++; if (nhr_address_o !== 3'b001) $display("FAIL midreset_addr: got %b exp 001", nhr_address_o); else n_pass++;
        n_total++; if ({nhr_write_o, route_valid_o, ib_drop_o, err_o, flit_cnt_o} !== {4'b0000, 3'd0})
            $display("FAIL midreset_flags: got wr=%b vld=%b drop=%b err=%b cnt=%0d exp all 0",
                     nhr_write_o, route_valid_o, ib_drop_o, err_o, flit_cnt_o); else n_pass++;
        reset = 1'b1;
        present(T_HEAD, 4'd3, 1'b0);
        tick();
        n_total++; if ({nhr_write_o, nhr_address_o, route_valid_o} !== {1'b1, 3'b100, 1'b1})
            $display("FAIL midreset_fresh: got wr=%b addr=%b vld=%b exp 1/100/1", nhr_write_o, nhr_address_o, route_valid_o); else n_pass++;
        go_empty();
        tick();
    endtask

    initial begin
        reset      = 1'b0;
        ib_empty_i = 1'b1;
        ib_read_i  = 1'b0;
        ib_flit_i  = '0;
        test_reset();
        test_route_local();
        test_east_packet();
        test_bubble();
        test_drop();
        do_reset();
        test_max_len();
        test_mid_head();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/s_route_compute.md
Name: s_route_compute

Overview:
- Per-input-port route computation stage of the NoC router. It sits directly upstream of the next-hop register.
- It watches the head flit of the input buffer, decodes the destination of each HEAD flit and issues a one-hot next-hop port with a one-cycle write strobe. It then holds the route until the packet's TAIL flit has been popped.
- It enforces packet framing and flags malformed traffic.

Parameters:
- FLIT_WIDTH, 32, total flit width in bits.
- NODE_ID_WIDTH, 4, width of the destination field and of the node ID.
- NODE_ID, 0, this router's position on the bidirectional line/ring.
- MAX_PKT_LEN, 16, maximum flits per packet including HEAD and TAIL.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-low (0 = reset), sampled on rising clk.
- ib_empty_i  input  1  input buffer empty; ib_flit_i is valid only when this is 0.
- ib_flit_i  input  FLIT_WIDTH  head-of-buffer flit. Bits [1:0] are the type: 00 BODY, 01 HEAD, 10 TAIL, 11 HEADTAIL. Bits [NODE_ID_WIDTH+1:2] are the destination.
- ib_read_i  input  1  the crossbar popped the head flit this cycle.
- nhr_address_o  output  3  one-hot next hop: 001 LOCAL, 010 EAST, 100 WEST.
- nhr_write_o  output  1  single-cycle write strobe to the next-hop register.
- route_valid_o  output  1  a route is held for the packet in flight.
- ib_drop_o  output  1  single-cycle pop request that discards a malformed flit.
- err_o  output  1  sticky framing/length error.
- flit_cnt_o  output  $clog2(MAX_PKT_LEN+1)  flits popped in the current packet.

Behaviour:
- All outputs are registered.
- Reset values:
  - nhr_address_o = 001.
  - nhr_write_o = 0, route_valid_o = 0, ib_drop_o = 0, err_o = 0.
  - flit_cnt_o = 0.
  - FSM = IDLE.
- Reset mid-packet abandons the packet immediately with the same values; the buffer contents are untouched.
- Route function, unsigned compare of dest against NODE_ID:
  - dest == NODE_ID -> 001.
  - dest > NODE_ID -> 010.
  - dest < NODE_ID -> 100.
- IDLE state:
  - !ib_empty_i and type HEAD or HEADTAIL: on the next edge, nhr_address_o = route, nhr_write_o = 1 for exactly one cycle, route_valid_o = 1, state -> ROUTED. Latency is 1 cycle from a head visible to the strobe.
  - !ib_empty_i and type BODY or TAIL: ib_drop_o = 1 for one cycle, err_o is set, state stays IDLE. ib_drop_o is never asserted on two consecutive cycles; the buffer needs a cycle to present the next flit.
  - ib_read_i while IDLE is ignored.
- ROUTED state:
  - nhr_address_o is held and nhr_write_o = 0.
  - Each ib_read_i increments flit_cnt_o.
  - ib_read_i on a flit of type TAIL or HEADTAIL: next edge route_valid_o = 0, flit_cnt_o = 0, state -> IDLE.
  - A HEAD or HEADTAIL flit seen as a non-first flit of the packet: set err_o, but still treat it as a body flit. A HEADTAIL ends the packet.
  - flit_cnt_o reaching MAX_PKT_LEN without a tail: set err_o, force state -> IDLE, route_valid_o = 0.
- Tail pop and next head in the same cycle: the FSM returns to IDLE first, so the new head is routed the following cycle. This one-cycle bubble is required behaviour.
- nhr_address_o keeps its last value in IDLE; the downstream register forces 001 itself when the buffer is empty.
- err_o clears only on reset.
- flit_cnt_o saturates at MAX_PKT_LEN.

Decomposition:
- Package noc_route_pkg holds:
  - the flit type enum;
  - port one-hot constants PORT_LOCAL, PORT_EAST, PORT_WEST;
  - flit field offsets;
  - the pure route function, shared with the other input ports.
- FSM state enum {IDLE, ROUTED} is local to the module.
- No sub-module; a single flat module of about 150–200 lines.

Test Plan:
- Reset with NODE_ID=5, present HEAD with dest=5 -> one cycle later nhr_write_o=1 and nhr_address_o=001 for one cycle; route_valid_o=1.
- HEAD dest=9, then BODY, BODY, TAIL popped on consecutive cycles -> address 010 held; flit_cnt_o counts 1,2,3; after the TAIL pop, route_valid_o=0 and flit_cnt_o=0.
- TAIL pop with the next HEAD (dest=2) already at the buffer head -> one idle cycle, then nhr_write_o=1 with address 100.
- BODY flit while IDLE -> ib_drop_o=1 for one cycle, err_o=1 sticky, no nhr_write_o.
- MAX_PKT_LEN=4, HEAD followed by 4 BODY pops with no TAIL -> err_o=1, FSM back to IDLE, route_valid_o=0.
- reset=0 in the middle of a packet -> next edge nhr_address_o=001 and all other outputs 0; a fresh HEAD afterwards is routed normally.
